// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM states,
// frame configuration payload and the data-bit length helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned LEN_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Per-frame settings captured when a word leaves the FIFO
  typedef struct packed {
    logic [LEN_W-1:0] nbits;
    logic             par_en;
    logic             stop2;
  } frame_cfg_t;

  function automatic logic [LEN_W-1:0] dbits_len(input logic [1:0] dbits);
    return LEN_W'(dbits) + LEN_W'(5);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full flag and occupancy count.
// Writes while full are ignored; reads while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_d;
  logic             push;
  logic             pop;

  assign push  = wr_en && !full;
  assign pop   = rd_en && (level != '0);
  assign rdata = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (push && !pop) begin
      level_d = level + LVL_W'(1);
    end else if (!push && pop) begin
      level_d = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d;
      full  <= (level_d == LVL_W'(DEPTH));
    end
  end

  // Storage carries no reset; only pointer-qualified entries are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: write FIFO feeding a frame engine with runtime data bits,
// parity, stop bits and baud divisor, all captured per frame.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DATA_MAX   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_dbits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          wr_en,
  input  logic [DATA_MAX-1:0]           wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          done
);

  tx_state_e           state;
  tx_state_e           state_d;
  logic [DIV_W-1:0]    baud;
  logic [DIV_W-1:0]    baud_d;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_d;
  frame_cfg_t          fcfg;
  frame_cfg_t          fcfg_d;
  logic                par_bit;
  logic                par_bit_d;
  logic                par_acc;
  logic [LEN_W-1:0]    bit_idx;
  logic [LEN_W-1:0]    bit_idx_d;
  logic [LEN_W-1:0]    cfg_len;
  logic                stop_idx;
  logic                stop_idx_d;
  logic [DATA_MAX-1:0] shreg;
  logic [DATA_MAX-1:0] shreg_d;
  logic [DATA_MAX-1:0] fifo_rdata;
  logic                tick;
  logic                pop;
  logic                tx_d;
  logic                busy_d;
  logic                done_d;
  logic                ovf_d;

  assign tick    = (baud == '0);
  assign pop     = (state == S_IDLE) && (level != '0);
  assign cfg_len = dbits_len(cfg_dbits);

  sync_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .wdata (wr_data),
    .rd_en (pop),
    .full  (full),
    .level (level),
    .rdata (fifo_rdata)
  );

  // State and datapath registers; outputs are registered from next values
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      div_q    <= '0;
      fcfg     <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      div_q    <= div_d;
      fcfg     <= fcfg_d;
      par_bit  <= par_bit_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      shreg    <= shreg_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      ovf      <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (pop) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick && (bit_idx == fcfg.nbits - LEN_W'(1))) begin
          state_d = fcfg.par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick && (stop_idx == fcfg.stop2)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values and registered-output drive
  always_comb begin
    baud_d     = tick ? div_q : (baud - DIV_W'(1));
    div_d      = div_q;
    fcfg_d     = fcfg;
    par_bit_d  = par_bit;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    shreg_d    = shreg;
    tx_d       = 1'b1;
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
    ovf_d      = ovf;

    par_acc = (cfg_parity == PAR_ODD);
    for (int i = 0; i < DATA_MAX; i++) begin
      if (LEN_W'(i) < cfg_len) par_acc = par_acc ^ fifo_rdata[i];
    end

    if (pop) begin
      baud_d        = cfg_div;
      div_d         = cfg_div;
      fcfg_d.nbits  = cfg_len;
      fcfg_d.par_en = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      fcfg_d.stop2  = cfg_stop2;
      par_bit_d     = par_acc;
      bit_idx_d     = '0;
      stop_idx_d    = 1'b0;
      shreg_d       = fifo_rdata;
    end

    if ((state == S_DATA) && tick) begin
      shreg_d   = shreg >> 1;
      bit_idx_d = bit_idx + LEN_W'(1);
    end

    if ((state == S_STOP) && tick) stop_idx_d = ~stop_idx;

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_bit_d;
      S_STOP:   done_d = (baud_d == '0) && (stop_idx_d == fcfg_d.stop2);
      default:  tx_d = 1'b1;
    endcase

    // A dropped write outranks a simultaneous clear
    if (ovf_clr) ovf_d = 1'b0;
    if (wr_en && full) ovf_d = 1'b1;
  end

endmodule
